rcb_bank: RTL

RCB_BANK -- requirements
Module: rcb_bank

---
 rtl/rcb_bank_if.sv | 34 +++
 rtl/rcb_bank.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rcb_bank_if.sv
// Lookup and host access bus for rcb_bank. The master side drives requests; the slave side
// (the bank) returns readies, read data and error pulses.
interface rcb_bank_if #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned RAM_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH = 14
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                        t2t_rd_valid;
  logic [ADDR_WIDTH-1:0]       t2t_rd_addr;
  logic                        t2t_rd_ready;
  logic                        rcb_valid;
  logic [NUM_CH*RAM_WIDTH-1:0] rcb_data;
  logic                        host_req;
  logic                        host_wr;
  logic [CH_W-1:0]             host_ch;
  logic [ADDR_WIDTH-1:0]       host_addr;
  logic [RAM_WIDTH-1:0]        host_wdata;
  logic                        host_ready;
  logic                        host_rvalid;
  logic [RAM_WIDTH-1:0]        host_rdata;
  logic                        host_err;

  modport master (
    output t2t_rd_valid, t2t_rd_addr, host_req, host_wr, host_ch, host_addr, host_wdata,
    input  t2t_rd_ready, rcb_valid, rcb_data, host_ready, host_rvalid, host_rdata, host_err
  );

  modport slave (
    input  t2t_rd_valid, t2t_rd_addr, host_req, host_wr, host_ch, host_addr, host_wdata,
    output t2t_rd_ready, rcb_valid, rcb_data, host_ready, host_rvalid, host_rdata, host_err
  );
endinterface

// File: rtl/rcb_bank.sv
// Bank of NUM_CH single-port RAMs shared between a wide lookup port (all channels at once)
// and a narrow host port, with a two-stage read pipeline on both paths.
module rcb_bank #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned RAM_WIDTH    = 64,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned HOST_ARB     = 0,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input logic       clk,
  input logic       reset_n,
  rcb_bank_if.slave bus_io
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned ScW   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [ScW-1:0] StarveMax = ScW'(STARVE_LIMIT);
  localparam logic [CH_W:0]  NumChL    = (CH_W + 1)'(NUM_CH);

  logic [ScW-1:0]              starve_q, starve_d;
  logic                        force_grant;
  logic                        lk_acc, h_acc, ch_bad, rd_en;
  logic [ADDR_WIDTH-1:0]       ram_addr;
  logic [NUM_CH-1:0]           we;
  logic [NUM_CH*RAM_WIDTH-1:0] rd_all;
  logic [RAM_WIDTH-1:0]        host_sel;

  logic                        lk_v1_q, hr_v1_q, err1_q;
  logic [CH_W-1:0]             hch1_q;
  logic                        rcb_valid_q, host_rvalid_q, host_err_q;
  logic [NUM_CH*RAM_WIDTH-1:0] rcb_data_q;
  logic [RAM_WIDTH-1:0]        host_rdata_q;

  always_comb begin
    force_grant = (STARVE_LIMIT != 0) && (starve_q == StarveMax);
    if (HOST_ARB != 0) begin
      bus_io.host_ready   = reset_n & bus_io.host_req;
      bus_io.t2t_rd_ready = reset_n & ~bus_io.host_req;
    end else begin
      bus_io.host_ready   = reset_n & bus_io.host_req & (~bus_io.t2t_rd_valid | force_grant);
      bus_io.t2t_rd_ready = reset_n & ~force_grant;
    end
    lk_acc   = bus_io.t2t_rd_valid & bus_io.t2t_rd_ready;
    h_acc    = bus_io.host_req & bus_io.host_ready;
    ch_bad   = {1'b0, bus_io.host_ch} >= NumChL;
    // The arbiter never grants both ports in one cycle, so one address serves every RAM.
    ram_addr = h_acc ? bus_io.host_addr : bus_io.t2t_rd_addr;
    rd_en    = lk_acc | (h_acc & ~bus_io.host_wr);
    for (int c = 0; c < NUM_CH; c++) begin
      we[c] = h_acc & bus_io.host_wr & (bus_io.host_ch == CH_W'(c));
    end
    starve_d = '0;
    if (bus_io.host_req & ~bus_io.host_ready) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [RAM_WIDTH-1:0] mem_q [Depth];
    logic [RAM_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (we[c]) begin
        mem_q[ram_addr] <= bus_io.host_wdata;
      end
      if (rd_en) begin
        rd_q <= mem_q[ram_addr];
      end
    end

    assign rd_all[c*RAM_WIDTH +: RAM_WIDTH] = rd_q;
  end

  always_comb begin
    host_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hch1_q == CH_W'(c)) begin
        host_sel = rd_all[c*RAM_WIDTH +: RAM_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_q      <= '0;
      lk_v1_q       <= 1'b0;
      hr_v1_q       <= 1'b0;
      err1_q        <= 1'b0;
      hch1_q        <= '0;
      rcb_valid_q   <= 1'b0;
      rcb_data_q    <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      host_err_q    <= 1'b0;
    end else begin
      starve_q      <= starve_d;
      lk_v1_q       <= lk_acc;
      hr_v1_q       <= h_acc & ~bus_io.host_wr;
      err1_q        <= h_acc & ch_bad;
      if (h_acc) begin
        hch1_q <= bus_io.host_ch;
      end
      rcb_valid_q   <= lk_v1_q;
      if (lk_v1_q) begin
        rcb_data_q <= rd_all;
      end
      host_rvalid_q <= hr_v1_q;
      // err1_q belongs to the same access as hr_v1_q; a bad channel reads as zero.
      if (hr_v1_q) begin
        host_rdata_q <= err1_q ? '0 : host_sel;
      end
      host_err_q    <= err1_q;
    end
  end

  assign bus_io.rcb_valid   = rcb_valid_q;
  assign bus_io.rcb_data    = rcb_data_q;
  assign bus_io.host_rvalid = host_rvalid_q;
  assign bus_io.host_rdata  = host_rdata_q;
  assign bus_io.host_err    = host_err_q;
endmodule
